// File: rtl/bus_master_if.sv
// ----------------------------------------------------------------------------
// bus_master_if
// Core-side bus master. The core issues one access at a time. The block
// requests the shared bus from the arbiter. Once granted, it drives an address
// strobe until the slave signals ready. It then reports completion to the core
// with a one-cycle pulse.
//
// Optional feature macro: BUS_MASTER_TIMEOUT_EN
//   defined   : an ACCESS-phase watchdog aborts the access after TIMEOUT_CYC
//               not-ready cycles and reports it through coreErr.
//   undefined : ACCESS waits for the slave indefinitely; coreErr is tied low.
//
// All outputs are either flops or pure decodes of the state register.
// Reset is synchronous and active high.
// ----------------------------------------------------------------------------
module bus_master_if #(
   parameter int unsigned ADDR_W      = 30,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              reset,
   // core side
   input  logic              coreReq,
   input  logic              coreRw,
   input  logic [ADDR_W-1:0] coreAddr,
   input  logic [DATA_W-1:0] coreWrData,
   output logic [DATA_W-1:0] coreRdData,
   output logic              coreBusy,
   output logic              coreDone,
   output logic              coreErr,
   // bus side
   output logic              busReq_,
   input  logic              busGrnt_,
   output logic              busAs_,
   output logic              busRw,
   output logic [ADDR_W-1:0] busAddr,
   output logic [DATA_W-1:0] busWrData,
   input  logic [DATA_W-1:0] busRdData,
   input  logic              busRdy_
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t              state_r;
   state_t              state_s;

   // request captured in IDLE and replayed for every (re)issued access
   logic                rw_r;
   logic [ADDR_W-1:0]   addr_r;
   logic [DATA_W-1:0]   wdata_r;

   logic [DATA_W-1:0]   rdata_r;
   logic                done_r;

   logic                latch_s;
   logic                capture_s;
   logic                done_s;
   logic                err_s;
   logic                in_access_s;

`ifdef BUS_MASTER_TIMEOUT_EN
   // one extra count value so the counter can never wrap while in ACCESS
   localparam int unsigned CNT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0]    cnt_r;
   logic                err_r;
   logic                timeout_s;

   assign timeout_s = (cnt_r == CNT_W'(TIMEOUT_CYC - 1));
`else
   // TIMEOUT_CYC is only meaningful in the watchdog build; this empty
   // block merely keeps the parameter referenced.
   if (TIMEOUT_CYC == 0) begin : g_timeout_unused
   end
`endif

   // Next-state and per-cycle control decode
   always_comb begin
      state_s   = state_r;
      latch_s   = 1'b0;
      capture_s = 1'b0;
      done_s    = 1'b0;
      err_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (coreReq) begin
               state_s = REQ;
               latch_s = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         REQ: begin
            if (!busGrnt_) begin
               state_s = ACCESS;
            end else begin
               state_s = REQ;
            end
         end
         ACCESS: begin
            // slave ready beats both watchdog expiry and grant loss
            if (!busRdy_) begin
               state_s   = IDLE;
               done_s    = 1'b1;
               capture_s = rw_r;
`ifdef BUS_MASTER_TIMEOUT_EN
            end else if (timeout_s) begin
               state_s = IDLE;
               done_s  = 1'b1;
               err_s   = 1'b1;
`endif
            end else if (busGrnt_) begin
               state_s = REQ;
            end else begin
               state_s = ACCESS;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Capture the core request when it is accepted
   always_ff @(posedge clk) begin
      if (reset) begin
         rw_r    <= 1'b0;
         addr_r  <= {ADDR_W{1'b0}};
         wdata_r <= {DATA_W{1'b0}};
      end else if (latch_s) begin
         rw_r    <= coreRw;
         addr_r  <= coreAddr;
         wdata_r <= coreWrData;
      end else begin
         rw_r    <= rw_r;
         addr_r  <= addr_r;
         wdata_r <= wdata_r;
      end
   end

   // Read data holds its value except when a read completes
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_r <= {DATA_W{1'b0}};
      end else if (capture_s) begin
         rdata_r <= busRdData;
      end else begin
         rdata_r <= rdata_r;
      end
   end

   // One-cycle completion pulse; reset drops any pending completion
   always_ff @(posedge clk) begin
      if (reset) begin
         done_r <= 1'b0;
      end else begin
         done_r <= done_s;
      end
   end

`ifdef BUS_MASTER_TIMEOUT_EN
   // Watchdog counting not-ready ACCESS cycles, restarted on every ACCESS entry
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == REQ) && (state_s == ACCESS)) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == ACCESS) && busRdy_) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Error qualifier travels alongside the completion pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         err_r <= 1'b0;
      end else begin
         err_r <= err_s;
      end
   end

   assign coreErr = err_r;
`else
   assign coreErr = 1'b0;
`endif

   // Output decode from registered state only
   assign in_access_s = (state_r == ACCESS);
   assign coreBusy    = (state_r == REQ) || (state_r == ACCESS);
   assign busReq_     = !coreBusy;
   assign busAs_      = !in_access_s;
   assign busRw       = in_access_s ? rw_r    : 1'b0;
   assign busAddr     = in_access_s ? addr_r  : {ADDR_W{1'b0}};
   assign busWrData   = in_access_s ? wdata_r : {DATA_W{1'b0}};
   assign coreDone    = done_r;
   assign coreRdData  = rdata_r;

endmodule

// File: tb/tb_bus_master_if.sv
// Self-checking bench for bus_master_if: directed steps, scoreboard of
// expected completions, immediate-assertion comparisons.
module tb_bus_master_if;

   localparam int unsigned ADDR_W = 30;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned TO_CYC = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              coreReq;
   logic              coreRw;
   logic [ADDR_W-1:0] coreAddr;
   logic [DATA_W-1:0] coreWrData;
   logic [DATA_W-1:0] coreRdData;
   logic              coreBusy;
   logic              coreDone;
   logic              coreErr;
   logic              busReq_;
   logic              busGrnt_;
   logic              busAs_;
   logic              busRw;
   logic [ADDR_W-1:0] busAddr;
   logic [DATA_W-1:0] busWrData;
   logic [DATA_W-1:0] busRdData;
   logic              busRdy_;

   typedef struct packed {
      logic [DATA_W-1:0] rdata;
      logic              err;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   done_seen;

   bus_master_if #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .TIMEOUT_CYC(TO_CYC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .coreReq   (coreReq),
      .coreRw    (coreRw),
      .coreAddr  (coreAddr),
      .coreWrData(coreWrData),
      .coreRdData(coreRdData),
      .coreBusy  (coreBusy),
      .coreDone  (coreDone),
      .coreErr   (coreErr),
      .busReq_   (busReq_),
      .busGrnt_  (busGrnt_),
      .busAs_    (busAs_),
      .busRw     (busRw),
      .busAddr   (busAddr),
      .busWrData (busWrData),
      .busRdData (busRdData),
      .busRdy_   (busRdy_)
   );

   always #5 clk = ~clk;

   // advance one clock; outputs are sampled and inputs driven 1 time unit later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // the current cycle must carry a completion pulse matching the scoreboard head
   task automatic expect_done(input string tag);
      exp_t e;
      check({tag, "_done"}, 64'(coreDone), 64'(1'b1));
      check({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'(1'b1));
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check({tag, "_rdata"}, 64'(coreRdData), 64'(e.rdata));
         check({tag, "_err"}, 64'(coreErr), 64'(e.err));
      end
   endtask

   task automatic push_exp(input logic [DATA_W-1:0] rdata, input logic err);
      exp_t e;
      e.rdata = rdata;
      e.err   = err;
      exp_q.push_back(e);
   endtask

   initial begin
      reset      = 1'b1;
      coreReq    = 1'b0;
      coreRw     = 1'b0;
      coreAddr   = '0;
      coreWrData = '0;
      busGrnt_   = 1'b1;
      busRdData  = '0;
      busRdy_    = 1'b1;

      // ---- reset state ----
      tick();
      tick();
      check("rst_busReq_", 64'(busReq_), 64'(1'b1));
      check("rst_busAs_", 64'(busAs_), 64'(1'b1));
      check("rst_busRw", 64'(busRw), 64'(1'b0));
      check("rst_busAddr", 64'(busAddr), 64'(0));
      check("rst_busWrData", 64'(busWrData), 64'(0));
      check("rst_coreRdData", 64'(coreRdData), 64'(0));
      check("rst_coreBusy", 64'(coreBusy), 64'(1'b0));
      check("rst_coreDone", 64'(coreDone), 64'(1'b0));
      check("rst_coreErr", 64'(coreErr), 64'(1'b0));
      reset = 1'b0;
      tick();

      // ---- read, minimum latency ----
      coreReq    = 1'b1;
      coreRw     = 1'b1;
      coreAddr   = 30'h0000100;
      coreWrData = 32'h0;
      busGrnt_   = 1'b0;
      busRdy_    = 1'b0;
      busRdData  = 32'hDEADBEEF;
      push_exp(32'hDEADBEEF, 1'b0);
      tick();                                   // edge N: accepted
      coreReq = 1'b0;
      check("rd_req_busReq_", 64'(busReq_), 64'(1'b0));
      check("rd_req_busAs_", 64'(busAs_), 64'(1'b1));
      check("rd_req_busy", 64'(coreBusy), 64'(1'b1));
      check("rd_req_busAddr", 64'(busAddr), 64'(0));
      tick();                                   // edge N+1: granted
      check("rd_acc_busAs_", 64'(busAs_), 64'(1'b0));
      check("rd_acc_busRw", 64'(busRw), 64'(1'b1));
      check("rd_acc_busAddr", 64'(busAddr), 64'(30'h0000100));
      check("rd_acc_nodone", 64'(coreDone), 64'(1'b0));
      tick();                                   // edge N+2: ready
      expect_done("rd");
      check("rd_done_busReq_", 64'(busReq_), 64'(1'b1));
      check("rd_done_busy", 64'(coreBusy), 64'(1'b0));
      tick();
      check("rd_pulse_one_cycle", 64'(coreDone), 64'(1'b0));

      // ---- write, grant delayed 5 cycles ----
      busGrnt_   = 1'b1;
      busRdy_    = 1'b1;
      busRdData  = 32'hCAFEF00D;
      coreReq    = 1'b1;
      coreRw     = 1'b0;
      coreAddr   = 30'h3FFFFFFF;
      coreWrData = 32'h12345678;
      tick();
      coreReq = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("wr_wait%0d_busReq_", i), 64'(busReq_), 64'(1'b0));
         check($sformatf("wr_wait%0d_busAs_", i), 64'(busAs_), 64'(1'b1));
         if (i == 4) busGrnt_ = 1'b0;
         tick();
      end
      check("wr_acc_busAs_", 64'(busAs_), 64'(1'b0));
      check("wr_acc_busRw", 64'(busRw), 64'(1'b0));
      check("wr_acc_busAddr", 64'(busAddr), 64'(30'h3FFFFFFF));
      check("wr_acc_busWrData", 64'(busWrData), 64'(32'h12345678));
      busRdy_ = 1'b0;
      push_exp(32'hDEADBEEF, 1'b0);              // write leaves read data alone
      tick();
      expect_done("wr");
      check("wr_done_busWrData", 64'(busWrData), 64'(0));
      busRdy_ = 1'b1;
      tick();

      // ---- grant lost in second ACCESS cycle ----
      busGrnt_   = 1'b0;
      coreReq    = 1'b1;
      coreRw     = 1'b1;
      coreAddr   = 30'h00002A0;
      tick();
      coreReq  = 1'b0;
      coreAddr = 30'h0000555;                   // must not disturb the latched address
      tick();
      check("gl_acc1_busAs_", 64'(busAs_), 64'(1'b0));
      check("gl_acc1_busAddr", 64'(busAddr), 64'(30'h00002A0));
      tick();
      check("gl_acc2_busAs_", 64'(busAs_), 64'(1'b0));
      busGrnt_ = 1'b1;
      tick();
      check("gl_lost_busAs_", 64'(busAs_), 64'(1'b1));
      check("gl_lost_busReq_", 64'(busReq_), 64'(1'b0));
      check("gl_lost_busy", 64'(coreBusy), 64'(1'b1));
      check("gl_lost_busAddr", 64'(busAddr), 64'(0));
      check("gl_lost_nodone", 64'(coreDone), 64'(1'b0));
      busGrnt_ = 1'b0;
      tick();
      check("gl_reissue_busAs_", 64'(busAs_), 64'(1'b0));
      check("gl_reissue_busAddr", 64'(busAddr), 64'(30'h00002A0));
      busRdy_   = 1'b0;
      busRdData = 32'h0BADF00D;
      push_exp(32'h0BADF00D, 1'b0);
      tick();
      expect_done("gl");
      busRdy_ = 1'b1;
      tick();

      // ---- back-to-back reads, coreReq held ----
      busGrnt_  = 1'b0;
      busRdy_   = 1'b0;
      busRdData = 32'h11111111;
      coreReq   = 1'b1;
      coreRw    = 1'b1;
      coreAddr  = 30'h10;
      push_exp(32'h11111111, 1'b0);
      tick();
      tick();
      check("b2b_a_busAddr", 64'(busAddr), 64'(30'h10));
      coreAddr = 30'h14;
      push_exp(32'h22222222, 1'b0);
      tick();
      expect_done("b2b_a");
      busRdData = 32'h22222222;
      tick();                                   // second request accepted in done cycle
      coreReq = 1'b0;
      check("b2b_b_busReq_", 64'(busReq_), 64'(1'b0));
      check("b2b_b_busy", 64'(coreBusy), 64'(1'b1));
      tick();
      check("b2b_b_busAddr", 64'(busAddr), 64'(30'h14));
      tick();
      expect_done("b2b_b");
      tick();

      // ---- not-ready slave: watchdog or indefinite wait ----
      busGrnt_ = 1'b0;
      busRdy_  = 1'b1;
      coreReq  = 1'b1;
      coreRw   = 1'b1;
      coreAddr = 30'h80;
      tick();
      coreReq = 1'b0;
      tick();                                   // first ACCESS cycle
`ifdef BUS_MASTER_TIMEOUT_EN
      push_exp(32'h22222222, 1'b1);
      for (int i = 1; i < int'(TO_CYC); i++) begin
         check($sformatf("to_acc%0d_busAs_", i), 64'(busAs_), 64'(1'b0));
         check($sformatf("to_acc%0d_nodone", i), 64'(coreDone), 64'(1'b0));
         tick();
      end
      check("to_last_busAs_", 64'(busAs_), 64'(1'b0));
      tick();
      expect_done("to");
      check("to_busAs_", 64'(busAs_), 64'(1'b1));
      tick();
`else
      done_seen = 0;
      for (int i = 0; i < 1000; i++) begin
         if (coreDone) done_seen++;
         tick();
      end
      check("nto_no_done", 64'(done_seen), 64'(0));
      check("nto_still_access", 64'(busAs_), 64'(1'b0));
      check("nto_err_low", 64'(coreErr), 64'(1'b0));
      busRdy_   = 1'b0;
      busRdData = 32'h33333333;
      push_exp(32'h33333333, 1'b0);
      tick();
      expect_done("nto");
      busRdy_ = 1'b1;
      tick();
`endif

      // ---- reset in the middle of ACCESS ----
      busGrnt_ = 1'b0;
      busRdy_  = 1'b1;
      coreReq  = 1'b1;
      coreRw   = 1'b1;
      coreAddr = 30'h40;
      tick();
      coreReq = 1'b0;
      tick();
      check("mr_acc_busAs_", 64'(busAs_), 64'(1'b0));
      reset   = 1'b1;
      busRdy_ = 1'b0;                           // ready arriving with reset must not complete
      tick();
      reset   = 1'b0;
      busRdy_ = 1'b1;
      check("mr_busReq_", 64'(busReq_), 64'(1'b1));
      check("mr_busAs_", 64'(busAs_), 64'(1'b1));
      check("mr_busy", 64'(coreBusy), 64'(1'b0));
      check("mr_nodone", 64'(coreDone), 64'(1'b0));
      check("mr_rdata_cleared", 64'(coreRdData), 64'(0));
      done_seen = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (coreDone) done_seen++;
      end
      check("mr_no_late_done", 64'(done_seen), 64'(0));
      check("sb_drained", 64'(exp_q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
